// File: rtl/key_pkg.sv
// Shared keycode constants and the key filter state encoding used by the
// key event filter and its downstream menu/game consumers.
package key_pkg;

  localparam logic [7:0] KEY_NONE  = 8'h00;
  localparam logic [7:0] KEY_DOWN  = 8'h51;
  localparam logic [7:0] KEY_UP    = 8'h52;
  localparam logic [7:0] KEY_ENTER = 8'h58;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HELD,
    REPEAT
  } kf_state_t;

endpackage

// File: rtl/frame_tick_gen.sv
// Converts the frame strobe into a single-Clk-cycle tick per rising edge.
// The delay flop resets high so a strobe already high at reset release is ignored.
module frame_tick_gen (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_clk,
  output logic tick
);

  logic frame_clk_d;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_clk_d <= 1'b1;
      tick        <= 1'b0;
    end else begin
      frame_clk_d <= frame_clk;
      tick        <= frame_clk & ~frame_clk_d;
    end
  end

endmodule

// File: rtl/key_event_filter.sv
// Debounces the raw keycode on frame ticks and emits press / auto-repeat
// events on a valid/ready handshake; fsm_state exposes the filter state.
module key_event_filter
  import key_pkg::*;
#(
  parameter int STABLE_FRAMES = 2,
  parameter int REPEAT_DELAY  = 30,
  parameter int REPEAT_RATE   = 6
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  output logic       event_valid,
  input  logic       event_ready,
  output logic [7:0] event_keycode,
  output logic       event_repeat,
  output logic       overrun,
  output logic [7:0] held_keycode,
  output kf_state_t  fsm_state
);

  localparam logic [3:0] STAB_TGT  = 4'(STABLE_FRAMES);
  localparam logic [7:0] DELAY_TGT = 8'(REPEAT_DELAY);
  localparam logic [7:0] RATE_TGT  = 8'(REPEAT_RATE);

  logic       tick;
  kf_state_t  state, state_n;
  logic [7:0] cand, cand_n;
  logic [3:0] stab_cnt, stab_n;
  logic [7:0] rpt_cnt, rpt_n;
  logic [7:0] held, held_n;
  logic       emit, emit_rep;

  frame_tick_gen u_tick (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (frame_clk),
    .tick      (tick)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      cand     <= KEY_NONE;
      stab_cnt <= '0;
      rpt_cnt  <= '0;
      held     <= KEY_NONE;
    end else begin
      state    <= state_n;
      cand     <= cand_n;
      stab_cnt <= stab_n;
      rpt_cnt  <= rpt_n;
      held     <= held_n;
    end
  end

  // Release clears the candidate so re-pressing the same key is debounced again.
  always_comb begin
    state_n  = state;
    cand_n   = cand;
    stab_n   = stab_cnt;
    rpt_n    = rpt_cnt;
    held_n   = held;
    emit     = 1'b0;
    emit_rep = 1'b0;
    if (tick) begin
      if (keycode == KEY_NONE) begin
        state_n = IDLE;
        cand_n  = KEY_NONE;
        stab_n  = '0;
        rpt_n   = '0;
        held_n  = KEY_NONE;
      end else if (keycode != cand) begin
        cand_n  = keycode;
        stab_n  = 4'd1;
        rpt_n   = '0;
        held_n  = KEY_NONE;
        state_n = DEBOUNCE;
        if (STABLE_FRAMES == 1) begin
          emit    = 1'b1;
          held_n  = keycode;
          state_n = HELD;
        end
      end else begin
        case (state)
          DEBOUNCE: begin
            stab_n = stab_cnt + 4'd1;
            if (stab_n == STAB_TGT) begin
              emit    = 1'b1;
              held_n  = cand;
              rpt_n   = '0;
              state_n = HELD;
            end
          end
          HELD: begin
            if (REPEAT_DELAY != 0) begin
              rpt_n = rpt_cnt + 8'd1;
              if (rpt_n == DELAY_TGT) begin
                emit     = 1'b1;
                emit_rep = 1'b1;
                rpt_n    = '0;
                state_n  = REPEAT;
              end
            end
          end
          REPEAT: begin
            rpt_n = rpt_cnt + 8'd1;
            if (rpt_n == RATE_TGT) begin
              emit     = 1'b1;
              emit_rep = 1'b1;
              rpt_n    = '0;
            end
          end
          default: state_n = IDLE;
        endcase
      end
    end
  end

  // Handshake: event_valid holds with a stable payload until a cycle with
  // event_valid & event_ready; a new emit always wins and loads the payload,
  // pulsing overrun only if the pending event was not taken that same cycle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      event_valid   <= 1'b0;
      event_keycode <= KEY_NONE;
      event_repeat  <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (emit) begin
        overrun       <= event_valid & ~event_ready;
        event_valid   <= 1'b1;
        event_keycode <= cand_n;
        event_repeat  <= emit_rep;
      end else if (event_valid && event_ready) begin
        event_valid <= 1'b0;
      end
    end
  end

  assign held_keycode = held;
  assign fsm_state    = state;

endmodule

// File: tb/tb_key_event_filter.sv
// Bench for key_event_filter: directed scenarios plus randomized key/frame
// stimulus against a run-length reference model of press/repeat events.
module tb_key_event_filter;
  import key_pkg::*;

  localparam int SF   = 2;
  localparam int RD   = 30;
  localparam int RATE = 6;

  // clock / reset
  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       Reset_n = 1'b0;
  logic       frame_clk = 1'b1;
  logic [7:0] keycode = 8'h00;
  logic       event_ready = 1'b0;

  logic       event_valid, event_repeat, overrun;
  logic [7:0] event_keycode, held_keycode;
  kf_state_t  fsm_state;

  logic       ev0_valid, ev0_repeat, ovr0;
  logic [7:0] ev0_keycode, held0;
  kf_state_t  state0;

  key_event_filter #(.STABLE_FRAMES(SF), .REPEAT_DELAY(RD), .REPEAT_RATE(RATE)) u_dut (
    .Clk(clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .keycode(keycode),
    .event_valid(event_valid), .event_ready(event_ready), .event_keycode(event_keycode),
    .event_repeat(event_repeat), .overrun(overrun), .held_keycode(held_keycode),
    .fsm_state(fsm_state)
  );

  key_event_filter #(.STABLE_FRAMES(SF), .REPEAT_DELAY(0), .REPEAT_RATE(RATE)) u_dut0 (
    .Clk(clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .keycode(keycode),
    .event_valid(ev0_valid), .event_ready(event_ready), .event_keycode(ev0_keycode),
    .event_repeat(ev0_repeat), .overrun(ovr0), .held_keycode(held0),
    .fsm_state(state0)
  );

  // scoreboard state
  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];

  // reference model: events follow from how many ticks the same key has been seen
  int         run;
  logic [7:0] run_key;
  logic       m_tick, m_fd;
  logic       m_valid, m_rep, m_ovr;
  logic [7:0] m_key, m_held;

  int acc_cnt, acc0_cnt, rep_acc, ovr_cnt, vcyc;
  logic [7:0] last_key;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    run = 0; run_key = 8'h00;
    m_tick = 1'b0; m_fd = 1'b1;
    m_valid = 1'b0; m_rep = 1'b0; m_ovr = 1'b0; m_key = 8'h00; m_held = 8'h00;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic emit, erep;
    emit = 1'b0; erep = 1'b0;
    if (m_tick) begin
      if (keycode == 8'h00) begin
        run = 0; run_key = 8'h00;
      end else if (run > 0 && keycode == run_key) begin
        run++;
      end else begin
        run = 1; run_key = keycode;
      end
      if (run > 0 && run == SF) emit = 1'b1;
      else if (RD > 0 && run >= SF + RD && ((run - SF - RD) % RATE) == 0) begin
        emit = 1'b1; erep = 1'b1;
      end
    end
    m_held = (run > 0 && run >= SF) ? run_key : 8'h00;
    m_ovr = 1'b0;
    if (emit) begin
      m_ovr = m_valid && !event_ready;
      m_valid = 1'b1; m_key = run_key; m_rep = erep;
      exp_q.push_back(run_key);
    end else if (m_valid && event_ready) begin
      m_valid = 1'b0;
    end
    m_tick = frame_clk & ~m_fd;
    m_fd = frame_clk;
  endtask

  // driver: called at a negedge, returns at the following negedge
  task automatic cycle(input logic fc, input logic [7:0] kc, input logic rdy);
    frame_clk = fc; keycode = kc; event_ready = rdy;
    if (event_valid) vcyc++;
    if (event_valid && event_ready) begin
      acc_cnt++; last_key = event_keycode;
      if (event_repeat) rep_acc++;
    end
    if (ev0_valid && event_ready) acc0_cnt++;
    if (overrun) ovr_cnt++;
    model_step();
    @(posedge clk); #1;
    check("event_valid", {31'd0, event_valid}, {31'd0, m_valid});
    check("event_keycode", {24'd0, event_keycode}, {24'd0, m_key});
    check("event_repeat", {31'd0, event_repeat}, {31'd0, m_rep});
    check("overrun", {31'd0, overrun}, {31'd0, m_ovr});
    check("held_keycode", {24'd0, held_keycode}, {24'd0, m_held});
    @(negedge clk);
  endtask

  task automatic do_reset(input logic fc, input logic [7:0] kc);
    Reset_n = 1'b0; frame_clk = fc; keycode = kc; event_ready = 1'b0;
    model_reset();
    #1;
    check("rst_valid", {31'd0, event_valid}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_held", {24'd0, held_keycode}, 32'd0);
    check("rst_keycode", {24'd0, event_keycode}, 32'd0);
    check("rst_state", {30'd0, fsm_state}, {30'd0, IDLE});
    @(negedge clk); @(negedge clk);
    Reset_n = 1'b1;
  endtask

  task automatic frames(input int n, input logic [7:0] kc, input logic rdy);
    for (int i = 0; i < n; i++) begin
      repeat (3) cycle(1'b0, kc, rdy);
      repeat (2) cycle(1'b1, kc, rdy);
    end
  endtask

  task automatic idle(input int n, input logic [7:0] kc, input logic rdy);
    repeat (n) cycle(1'b0, kc, rdy);
  endtask

  task automatic rand_frames(input int n, input logic [7:0] kc, input int bias);
    int lo, hi;
    for (int i = 0; i < n; i++) begin
      lo = $urandom_range(1, 4);
      hi = $urandom_range(1, 4);
      repeat (lo) cycle(1'b0, kc, $urandom_range(0, 99) < bias);
      repeat (hi) cycle(1'b1, kc, $urandom_range(0, 99) < bias);
    end
  endtask

  task automatic clear_counts();
    acc_cnt = 0; acc0_cnt = 0; rep_acc = 0; ovr_cnt = 0; vcyc = 0; last_key = 8'h00;
  endtask

  initial begin
    logic [7:0] k;
    int sel;
    @(negedge clk);

    // reset released with frame_clk high: no tick until a fresh edge
    do_reset(1'b1, KEY_UP);
    clear_counts();
    repeat (6) cycle(1'b1, KEY_UP, 1'b1);
    frames(1, KEY_UP, 1'b1);
    idle(3, KEY_UP, 1'b1);
    check("no_tick_at_release", acc_cnt, 0);
    frames(1, KEY_UP, 1'b1);
    idle(3, KEY_UP, 1'b1);
    check("press_after_2_ticks", acc_cnt, 1);
    frames(1, KEY_NONE, 1'b1);
    idle(3, KEY_NONE, 1'b1);

    // single press, one-cycle valid pulse
    clear_counts();
    frames(2, KEY_UP, 1'b1);
    idle(3, KEY_UP, 1'b1);
    check("up_events", acc_cnt, 1);
    check("up_valid_cycles", vcyc, 1);
    check("up_key", {24'd0, last_key}, 32'h52);
    check("up_held", {24'd0, held_keycode}, 32'h52);
    check("up_not_repeat", rep_acc, 0);
    frames(1, KEY_NONE, 1'b1);
    idle(3, KEY_NONE, 1'b1);

    // 45 ticks held: press plus repeats at 32, 38, 44
    clear_counts();
    frames(45, KEY_DOWN, 1'b1);
    idle(3, KEY_DOWN, 1'b1);
    check("down45_events", acc_cnt, 4);
    check("down45_repeats", rep_acc, 3);
    check("down45_nodelay_events", acc0_cnt, 1);
    frames(1, KEY_NONE, 1'b1);
    idle(3, KEY_NONE, 1'b1);

    // key A for 1 tick then key B: only B is reported
    clear_counts();
    frames(1, KEY_UP, 1'b1);
    frames(2, KEY_DOWN, 1'b1);
    idle(3, KEY_DOWN, 1'b1);
    check("a_to_b_events", acc_cnt, 1);
    check("a_to_b_key", {24'd0, last_key}, 32'h51);
    frames(1, KEY_NONE, 1'b1);
    idle(3, KEY_NONE, 1'b1);

    // consumer stalled through first repeat: overwrite with overrun
    clear_counts();
    frames(32, KEY_ENTER, 1'b0);
    idle(3, KEY_ENTER, 1'b0);
    check("stall_overrun", ovr_cnt, 1);
    check("stall_key", {24'd0, event_keycode}, 32'h58);
    check("stall_repeat", {31'd0, event_repeat}, 32'd1);
    cycle(1'b0, KEY_ENTER, 1'b1);
    cycle(1'b0, KEY_ENTER, 1'b0);
    check("stall_drop", {31'd0, event_valid}, 32'd0);
    frames(1, KEY_NONE, 1'b1);
    idle(3, KEY_NONE, 1'b1);

    // release on the tick that would complete debounce
    clear_counts();
    frames(1, KEY_UP, 1'b1);
    frames(1, KEY_NONE, 1'b1);
    idle(3, KEY_NONE, 1'b1);
    check("early_release_events", acc_cnt, 0);
    check("early_release_state", {30'd0, fsm_state}, {30'd0, IDLE});
    check("early_release_held", {24'd0, held_keycode}, 32'd0);

    // 100 ticks: 13 events normally, 1 with auto-repeat disabled
    clear_counts();
    frames(100, KEY_DOWN, 1'b1);
    idle(3, KEY_DOWN, 1'b1);
    check("hold100_events", acc_cnt, 13);
    check("hold100_nodelay_events", acc0_cnt, 1);
    frames(1, KEY_NONE, 1'b1);
    idle(3, KEY_NONE, 1'b1);

    // reset mid-handshake with key still held: must debounce again
    frames(2, KEY_ENTER, 1'b0);
    idle(2, KEY_ENTER, 1'b0);
    do_reset(1'b0, KEY_ENTER);
    clear_counts();
    frames(1, KEY_ENTER, 1'b1);
    idle(3, KEY_ENTER, 1'b1);
    check("rst_hold_first_tick", acc_cnt, 0);
    frames(1, KEY_ENTER, 1'b1);
    idle(3, KEY_ENTER, 1'b1);
    check("rst_hold_redebounce", acc_cnt, 1);

    // randomized segments against the reference model
    for (int s = 0; s < 140; s++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1:    k = KEY_NONE;
        2, 3:    k = KEY_DOWN;
        4, 5:    k = KEY_UP;
        6:       k = KEY_ENTER;
        default: k = 8'($urandom_range(1, 255));
      endcase
      if ($urandom_range(0, 29) == 0) do_reset(1'($urandom_range(0, 1)), k);
      rand_frames($urandom_range(1, 45), k, $urandom_range(0, 100));
    end
    idle(4, keycode, 1'b1);
    check("model_queue_nonempty", {31'd0, exp_q.size() > 0}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/key_event_filter.md
Name: key_event_filter

Overview:
Sits directly upstream of the menu and game-control logic, between the USB keyboard keycode register and its consumers. It turns the raw, level-style 8-bit keycode into debounced, frame-synchronous key-press events with auto-repeat. Events are offered on a valid/ready handshake, so the menu receives exactly one event per press or repeat and never a raw level.

Parameters:
STABLE_FRAMES, 2, number of consecutive frame ticks a non-zero keycode must be sampled unchanged before a press event is emitted (legal range 1..15)
REPEAT_DELAY, 30, frame ticks from the press event to the first repeat event; 0 disables auto-repeat (range 0..255)
REPEAT_RATE, 6, frame ticks between consecutive repeat events (range 1..255)

Ports:
Clk  input  1  50 MHz system clock; every flop in the block is on this clock
Reset_n  input  1  asynchronous, active-low reset
frame_clk  input  1  ~60 Hz frame strobe from the VGA controller; synchronous to Clk
keycode  input  8  raw keycode from the keyboard interface; 8'h00 means no key
event_valid  output  1  an event is pending
event_ready  input  1  consumer accepts the pending event
event_keycode  output  8  keycode of the pending event
event_repeat  output  1  1 = auto-repeat event, 0 = initial press
overrun  output  1  one-cycle pulse when an unaccepted event is overwritten
held_keycode  output  8  currently debounced held key; 8'h00 when none

Behaviour:
- Reset (asserted, asynchronous):
  - All outputs go to 0; FSM goes to IDLE; candidate and counters are cleared.
  - The internal frame_clk delay flop resets to 1, so a frame_clk that is already high at reset release does not produce a tick.
- Frame tick:
  - tick is registered: frame_clk_d <= frame_clk; tick <= frame_clk & ~frame_clk_d.
  - tick is high for exactly one Clk cycle per frame_clk rising edge.
  - The FSM and all counters change only in cycles where tick = 1. The handshake logic runs every cycle.
- FSM states: IDLE, DEBOUNCE, HELD, REPEAT. The following is evaluated on tick:
  - keycode == 8'h00, from any state: go to IDLE, clear held_keycode, emit no event. Release is immediate and not debounced.
  - keycode != 8'h00 and keycode != cand: cand <= keycode, stab_cnt <= 1, go to DEBOUNCE. This includes a change from key A straight to key B, so held_keycode is cleared.
  - DEBOUNCE with keycode == cand: stab_cnt increments. When the incremented value equals STABLE_FRAMES:
    - emit a press event (repeat = 0)
    - held_keycode <= cand, rpt_cnt <= 0, go to HELD
  - With STABLE_FRAMES = 1, the press is emitted on the first tick that sees the new key.
  - HELD: if REPEAT_DELAY == 0, stay in HELD with no further events. Otherwise rpt_cnt increments; at rpt_cnt == REPEAT_DELAY, emit a repeat event, reset rpt_cnt to 0 and go to REPEAT.
  - REPEAT: rpt_cnt increments; at rpt_cnt == REPEAT_RATE, emit a repeat event and reset rpt_cnt to 0.
- Latency:
  - An emitted event is registered, so event_valid rises in the Clk cycle after the tick cycle.
  - That is 2 Clk cycles after the frame_clk edge becomes visible on the input.
- Handshake:
  - event_valid stays high, with event_keycode and event_repeat stable, until a cycle in which event_valid & event_ready; it falls the next cycle.
  - event_ready while event_valid = 0 has no effect.
  - Emit while a pending event is not accepted that cycle: the payload is overwritten with the newer event, event_valid stays 1 and overrun pulses for 1 cycle.
  - Emit in the same cycle as acceptance: the new event is loaded, event_valid stays 1 and overrun stays 0.
- Counter widths:
  - stab_cnt is 4 bits.
  - rpt_cnt is 8 bits; it never exceeds max(REPEAT_DELAY, REPEAT_RATE), so it cannot wrap.
- Reset mid-hold or mid-handshake: the pending event is discarded. After release, a still-held key must be debounced again before any event.

Decomposition:
- Package key_pkg holds:
  - keycode constants KEY_NONE = 8'h00, KEY_DOWN = 8'h51, KEY_UP = 8'h52, KEY_ENTER = 8'h58
  - typedef enum logic [1:0] kf_state_t {IDLE, DEBOUNCE, HELD, REPEAT}
- One sub-module, frame_tick_gen (Clk, Reset_n, frame_clk -> tick). The menu and game-logic blocks reuse it.

Test Plan:
- Reset release with frame_clk held at 1 -> no tick and event_valid = 0 until the next 0->1 edge of frame_clk.
- keycode = 8'h52 held across 2 ticks, event_ready = 1 -> a single event_valid pulse 1 cycle long with event_keycode = 8'h52 and event_repeat = 0; held_keycode = 8'h52.
- keycode = 8'h51 held for 45 ticks, ready = 1 -> press at tick 2, repeats at ticks 32, 38 and 44 with event_repeat = 1; no other events.
- keycode 8'h52 for 1 tick, then 8'h51 for 2 ticks -> exactly one event, with keycode 8'h51; no event for 8'h52.
- event_ready = 0; press 8'h58 held through its first repeat -> event_keycode becomes 8'h58 with repeat = 1 and overrun pulses once. Raising ready, with no further emit, drops event_valid the following cycle.
- Release to 8'h00 on the tick where DEBOUNCE would complete -> no event; IDLE; held_keycode = 8'h00.
- REPEAT_DELAY = 0 build, key held 100 ticks -> exactly one press event.
